// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, both on operand
// magnitudes, one iteration per cycle for XLEN cycles. Signs and the
// divide-by-zero / signed-overflow cases are resolved in the DONE state so the
// latency never depends on the operation or the operand values.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // rs1 is signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic op_a_signed(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b110: op_a_signed = 1'b1;
            default:                                op_a_signed = 1'b0;
        endcase
    endfunction

    // rs2 is signed for MUL, MULH, DIV and REM
    function automatic logic op_b_signed(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: op_b_signed = 1'b1;
            default:                        op_b_signed = 1'b0;
        endcase
    endfunction

    // two's-complement magnitude; the most-negative value maps to itself,
    // which is the correct unsigned magnitude
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic neg);
        magnitude = neg ? (~x + XLEN'(1)) : x;
    endfunction

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_srca;
    logic [XLEN-1:0]     r_srcb;
    logic [XLEN-1:0]     r_opnd;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   r_prod;     // {hi, lo} product or {remainder, quotient}
    logic [XLEN-1:0]     r_result;
    logic                r_busy;
    logic                r_done;

    logic                w_in_a_neg;
    logic                w_in_b_neg;
    logic [XLEN-1:0]     w_in_a_mag;
    logic [XLEN-1:0]     w_in_b_mag;
    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_rem_shift;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [2*XLEN-1:0]   w_div_next;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic [2*XLEN-1:0]   w_prod_signed;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_result;

    // operand magnitudes of the incoming request, used when it is latched
    always_comb begin
        w_in_a_neg = op_a_signed(funct3) & srca[XLEN-1];
        w_in_b_neg = op_b_signed(funct3) & srcb[XLEN-1];
        w_in_a_mag = magnitude(srca, w_in_a_neg);
        w_in_b_mag = magnitude(srcb, w_in_b_neg);
    end

    // one shift-add step and one restoring-division step on the working register
    always_comb begin
        w_sum       = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
        w_mul_next  = r_prod[0] ? {w_sum, r_prod[XLEN-1:1]}
                                : {1'b0, r_prod[2*XLEN-1:1]};
        w_rem_shift = r_prod[2*XLEN-1:XLEN-1];
        w_diff      = w_rem_shift - {1'b0, r_opnd};
        if (w_diff[XLEN]) begin
            w_div_next = {w_rem_shift[XLEN-1:0], r_prod[XLEN-2:0], 1'b0};
        end else begin
            w_div_next = {w_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};
        end
    end

    // final result: apply signs and the divide special cases to the raw magnitudes
    always_comb begin
        w_a_neg       = op_a_signed(r_op) & r_srca[XLEN-1];
        w_b_neg       = op_b_signed(r_op) & r_srcb[XLEN-1];
        w_div_zero    = (r_srcb == {XLEN{1'b0}});
        w_div_ovf     = op_a_signed(r_op) & (r_srca == MOST_NEG) & (r_srcb == {XLEN{1'b1}});
        w_prod_signed = (w_a_neg ^ w_b_neg) ? (~r_prod + (2*XLEN)'(1)) : r_prod;
        w_quo         = r_prod[XLEN-1:0];
        w_rem         = r_prod[2*XLEN-1:XLEN];
        case (r_op)
            3'b000: w_result = w_prod_signed[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_result = w_prod_signed[2*XLEN-1:XLEN];
            3'b100, 3'b101: begin
                if (w_div_zero) begin
                    w_result = {XLEN{1'b1}};
                end else if (w_div_ovf) begin
                    w_result = r_srca;
                end else begin
                    w_result = magnitude(w_quo, w_a_neg ^ w_b_neg);
                end
            end
            3'b110, 3'b111: begin
                if (w_div_zero) begin
                    w_result = r_srca;
                end else if (w_div_ovf) begin
                    w_result = {XLEN{1'b0}};
                end else begin
                    w_result = magnitude(w_rem, w_a_neg);
                end
            end
            default: w_result = {XLEN{1'b0}};
        endcase
    end

    // control FSM, iteration counter, working registers and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_op     <= 3'b000;
            r_srca   <= {XLEN{1'b0}};
            r_srcb   <= {XLEN{1'b0}};
            r_opnd   <= {XLEN{1'b0}};
            r_prod   <= {(2*XLEN){1'b0}};
            r_result <= {XLEN{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op    <= funct3;
                        r_srca  <= srca;
                        r_srcb  <= srcb;
                        r_cnt   <= {CW{1'b0}};
                        r_opnd  <= funct3[2] ? w_in_b_mag : w_in_a_mag;
                        r_prod  <= {{XLEN{1'b0}}, (funct3[2] ? w_in_a_mag : w_in_b_mag)};
                        r_state <= funct3[2] ? S_DIV : S_MUL;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    r_prod <= w_mul_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_MUL;
                    end
                end
                S_DIV: begin
                    r_prod <= w_div_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_DIV;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // outputs trail the state by one edge: busy spans the iterations, done the DONE cycle
            r_busy <= (r_state == S_MUL) || (r_state == S_DIV);
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                r_result <= w_result;
            end else begin
                r_result <= r_result;
            end
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized checks of muldiv_seq (XLEN = 32)
// against an arithmetic reference model.
module tb_muldiv_seq;
    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_result = 32'd0;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .srca   (srca),
        .srcb   (srcb),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // RV32M semantics from plain integer arithmetic
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return 32'(sa / sb);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(5, 0))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(20, 1));
            default: return 32'($urandom());
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // present a request and let the sampling edge take it
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct3 = op;
        srca   = a;
        srcb   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // follow the 33 cycles after an accepted start; optionally poke start mid-run
    // or drop a held start once the next request has been taken
    task automatic watch(input logic [31:0] exp, input string tag, input int poke, input bit release_end);
        logic exp_busy;
        logic exp_done;
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk);
            #1;
            exp_busy = (i <= 32);
            exp_done = (i == 33);
            check($sformatf("%s busy c%0d", tag, i), {31'd0, busy}, {31'd0, exp_busy});
            check($sformatf("%s done c%0d", tag, i), {31'd0, done}, {31'd0, exp_done});
            check($sformatf("%s result c%0d", tag, i), result, (i == 33) ? exp : last_result);
            if (i == poke) begin
                start  = 1'b1;
                funct3 = funct3 ^ 3'b001;
                srca   = ~srca;
                srcb   = srcb + 32'd3;
            end else if (i == poke + 1) begin
                start  = 1'b0;
            end
            if (release_end && i == 33) begin
                start = 1'b0;
            end
        end
        last_result = exp;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        issue(op, a, b);
        watch(exp, tag, -10, 1'b0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        clk    = 1'b0;
        reset  = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        srca   = 32'd0;
        srcb   = 32'd0;

        // reset state
        #23;
        check("rst result", result, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // directed vectors
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem");
        run_op(3'd5, 32'd100, 32'd7, 32'd14, "divu");
        run_op(3'd7, 32'd100, 32'd7, 32'd2, "remu");
        run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu by0");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, "rem by0");
        run_op(3'd4, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF, "div neg by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem ovf");

        // start while busy is ignored and the latched operands survive
        issue(3'd4, 32'd1000, 32'd9);
        watch(32'd111, "div poke", 5, 1'b0);

        // back-to-back: start held high, second request taken in the DONE cycle
        issue(3'd0, 32'd6, 32'd9);
        start  = 1'b1;
        funct3 = 3'd7;
        srca   = 32'd50;
        srcb   = 32'd8;
        watch(32'd54, "b2b first", -10, 1'b1);
        watch(32'd2, "b2b second", -10, 1'b0);

        // reset mid-division aborts without a done pulse
        issue(3'd4, 32'd77, 32'd5);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort busy c%0d", i), {31'd0, busy}, 32'd1);
        end
        reset = 1'b1;
        #1;
        check("abort rst busy", {31'd0, busy}, 32'd0);
        check("abort rst done", {31'd0, done}, 32'd0);
        check("abort rst result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        last_result = 32'd0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post abort done c%0d", i), {31'd0, done}, 32'd0);
            check($sformatf("post abort busy c%0d", i), {31'd0, busy}, 32'd0);
        end
        run_op(3'd0, 32'd3, 32'd4, 32'd12, "mul after rst");

        // randomized operations against the model
        for (int n = 0; n < 48; n++) begin
            op = 3'($urandom_range(7, 0));
            a  = pick_operand();
            b  = pick_operand();
            run_op(op, a, b, model(op, a, b), $sformatf("rand%0d op%0d %h %h", n, op, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width; SHALL support any even value of 8 or more.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request; sampled only while the block is idle or done.
REQ-005 Port: funct3  input  3  RV32M operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: srca  input  XLEN  operand rs1 / dividend.
REQ-007 Port: srcb  input  XLEN  operand rs2 / divisor.
REQ-008 Port: result  output  XLEN  registered result.
REQ-009 Port: busy  output  1  high while an operation is in progress.
REQ-010 Port: done  output  1  one-cycle pulse; result is valid in that cycle.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-012 IDLE or DONE with start=1 SHALL latch funct3, srca and srcb, then go to MUL if funct3[2]=0, else to DIV.
REQ-013 DONE with start=0 SHALL go to IDLE.
REQ-014 MUL and DIV SHALL each run exactly XLEN iterations, one per cycle, driven by an internal counter of width clog2(XLEN)+1, then go to DONE.
REQ-015 Timing for a start sampled at edge k: busy SHALL be 1 after edges k+1 .. k+XLEN; done SHALL be 1 after edge k+XLEN+1 only.
REQ-016 Latency SHALL be fixed for all operations and operand values, including the special cases below.
REQ-017 start while busy=1 SHALL be ignored; latched operands SHALL stay unchanged.
REQ-018 result SHALL hold its last value until the next done pulse; done and busy SHALL never both be 1.
REQ-019 MUL: shift-add on operand magnitudes into a 2*XLEN-bit product, with the sign applied at completion. Result by op:
  MUL = low XLEN bits;
  MULH = high bits, signed x signed;
  MULHSU = high bits, signed srca x unsigned srcb;
  MULHU = high bits, unsigned x unsigned.
REQ-020 DIV: restoring division on magnitudes. Quotient sign = XOR of operand signs (DIV only); remainder sign = dividend sign (REM only).
REQ-021 Divisor = 0: DIV/DIVU SHALL return all-ones; REM/REMU SHALL return the dividend.
REQ-022 Signed overflow (DIV/REM, srca = most-negative, srcb = -1): DIV SHALL return srca; REM SHALL return 0.
REQ-023 start in the DONE cycle SHALL be accepted, giving back-to-back operations XLEN+1 cycles apart.

Reset
REQ-024 While reset=1, asynchronously: state=IDLE, counter=0, result=0, busy=0, done=0, internal operand and accumulator registers=0.
REQ-025 Reset during MUL or DIV SHALL abort the operation with no done pulse; the first start after reset release SHALL behave per REQ-015.

Verification (XLEN=32)
REQ-026 MUL, srca=7, srcb=0xFFFFFFFD -> result=0xFFFFFFEB, done exactly 33 cycles after the start edge; busy high for 32 cycles.
REQ-027 MULHU, srca=srcb=0xFFFFFFFF -> 0xFFFFFFFE. MULH, same operands -> 0x00000000. MULHSU, same operands -> 0xFFFFFFFF.
REQ-028 DIV, srca=0xFFFFFFF9, srcb=2 -> 0xFFFFFFFD. REM, same operands -> 0xFFFFFFFF. DIVU, srca=100, srcb=7 -> 14. REMU, same operands -> 2.
REQ-029 DIVU, srca=5, srcb=0 -> 0xFFFFFFFF. REM, same operands -> 5. DIV, srca=0x80000000, srcb=0xFFFFFFFF -> 0x80000000. REM, same operands -> 0. All at 33-cycle latency.
REQ-030 Start pulsed again at cycle 5 of a DIV with changed operands -> ignored; the original result is returned at cycle 33.
REQ-031 Reset at cycle 10 of a DIV -> busy=0, done=0, result=0 immediately with no later done pulse. Then MUL 3x4 -> 12 after 33 cycles.
